// File: rtl/orbit_pkg.sv
// Shared types and constants for the orbit period detector.
package orbit_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    SEARCH,
    LOCKED
  } state_t;

  localparam int DEFAULT_DEPTH   = 16;
  localparam int DEFAULT_CONFIRM = 4;

  localparam logic [15:0] TCOUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/orbit_period_detector_if.sv
// Sample input and status output bundle of the orbit period detector.
interface orbit_period_detector_if
  import orbit_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) ();

  localparam int PW = $clog2(DEPTH + 1);

  logic          sample_valid;
  logic [7:0]    sample;
  logic          locked;
  logic [PW-1:0] period;
  logic          fixed_point;
  logic          lock_pulse;
  logic          lost_pulse;
  logic [15:0]   transient_count;

  modport master (
    output sample_valid, sample,
    input  locked, period, fixed_point, lock_pulse, lost_pulse, transient_count
  );

  modport slave (
    input  sample_valid, sample,
    output locked, period, fixed_point, lock_pulse, lost_pulse, transient_count
  );

endinterface

// File: rtl/orbit_match_encoder.sv
// Compares a new sample against the stored history and reports the
// shortest lag at which it repeats.
module orbit_match_encoder #(
  parameter int DEPTH = 16,
  parameter int PW    = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0][7:0] hist,
  input  logic [PW-1:0]         fill,
  input  logic [7:0]            sample,
  output logic [DEPTH-1:0]      match,
  output logic [PW-1:0]         first
);

  // NOTE: every output gets a default before the loops so no latch is inferred.
  always_comb begin
    match = '0;
    first = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = (hist[i] == sample) && (i < int'(fill));
    end
    // Scan from the oldest entry down so the lowest matching lag wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) first = PW'(i + 1);
    end
  end

endmodule

// File: rtl/orbit_period_detector.sv
// Classifies an 8-bit map orbit: finds the shortest repetition period,
// locks after CONFIRM full periods and flags departure from the cycle.
module orbit_period_detector
  import orbit_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int CONFIRM = DEFAULT_CONFIRM
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  orbit_period_detector_if.slave  bus
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(DEPTH * CONFIRM + 1);

  state_t                state, state_n;
  logic [DEPTH-1:0][7:0] hist;
  logic [PW-1:0]         fill, fill_n;
  logic [PW-1:0]         cand, cand_n;
  logic [RW-1:0]         run, run_n;
  logic [PW-1:0]         period, period_n;
  logic                  locked, locked_n;
  logic                  fixed_point, fixed_point_n;
  logic                  lock_pulse, lock_pulse_n;
  logic                  lost_pulse, lost_pulse_n;
  logic [15:0]           tcount, tcount_n;

  logic [DEPTH-1:0] match;
  logic [PW-1:0]    first;
  logic [7:0]       cand_word, period_word;
  logic             cand_hit;
  logic [PW-1:0]    sel_cand;
  logic [RW-1:0]    sel_run;
  logic             sel_lock;
  logic [15:0]      tcount_inc;

  orbit_match_encoder #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_match (
    .hist   (hist),
    .fill   (fill),
    .sample (bus.sample),
    .match  (match),
    .first  (first)
  );

  // History word at lag cand and at lag period; lag 0 selects nothing.
  always_comb begin
    cand_word   = '0;
    period_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(cand) == i + 1)   cand_word   = hist[i];
      if (int'(period) == i + 1) period_word = hist[i];
    end
  end

  // Search rule: keep the current candidate while it matches, otherwise
  // reselect the shortest matching lag. Shared by SEARCH and loss of lock.
  always_comb begin
    cand_hit = (cand != '0) && (cand_word == bus.sample);
    if (cand_hit) begin
      sel_cand = cand;
      sel_run  = run + RW'(1);
    end else begin
      sel_cand = first;
      sel_run  = (match != '0) ? RW'(1) : '0;
    end
    sel_lock   = (sel_cand != '0) && (int'(sel_run) == int'(sel_cand) * CONFIRM);
    tcount_inc = (tcount == TCOUNT_MAX) ? tcount : tcount + 16'd1;
  end

  always_comb begin
    state_n       = state;
    fill_n        = fill;
    cand_n        = cand;
    run_n         = run;
    period_n      = period;
    locked_n      = locked;
    fixed_point_n = fixed_point;
    lock_pulse_n  = 1'b0;
    lost_pulse_n  = 1'b0;
    tcount_n      = tcount;

    if (bus.sample_valid) begin
      fill_n = (fill == PW'(DEPTH)) ? fill : fill + PW'(1);
      unique case (state)
        EMPTY: begin
          state_n  = SEARCH;
          cand_n   = '0;
          run_n    = '0;
          tcount_n = tcount_inc;
        end
        SEARCH: begin
          cand_n   = sel_cand;
          run_n    = sel_run;
          tcount_n = tcount_inc;
          if (sel_lock) begin
            state_n       = LOCKED;
            locked_n      = 1'b1;
            period_n      = sel_cand;
            fixed_point_n = (sel_cand == PW'(1));
            lock_pulse_n  = 1'b1;
          end
        end
        LOCKED: begin
          if (period_word != bus.sample) begin
            state_n       = SEARCH;
            locked_n      = 1'b0;
            period_n      = '0;
            fixed_point_n = 1'b0;
            lost_pulse_n  = 1'b1;
            cand_n        = sel_cand;
            run_n         = sel_run;
            tcount_n      = 16'd1;
            if (sel_lock) begin
              state_n       = LOCKED;
              locked_n      = 1'b1;
              period_n      = sel_cand;
              fixed_point_n = (sel_cand == PW'(1));
              lock_pulse_n  = 1'b1;
            end
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      fill        <= '0;
      cand        <= '0;
      run         <= '0;
      period      <= '0;
      locked      <= 1'b0;
      fixed_point <= 1'b0;
      lock_pulse  <= 1'b0;
      lost_pulse  <= 1'b0;
      tcount      <= '0;
    end else begin
      fill        <= fill_n;
      cand        <= cand_n;
      run         <= run_n;
      period      <= period_n;
      locked      <= locked_n;
      fixed_point <= fixed_point_n;
      lock_pulse  <= lock_pulse_n;
      lost_pulse  <= lost_pulse_n;
      tcount      <= tcount_n;
    end
  end

  // NOTE: the history is not reset; entries at or beyond fill are masked out.
  always_ff @(posedge clk) begin
    if (!reset && !clear && bus.sample_valid) begin
      hist <= {hist[DEPTH-2:0], bus.sample};
    end
  end

  assign bus.locked          = locked;
  assign bus.period          = period;
  assign bus.fixed_point     = fixed_point;
  assign bus.lock_pulse      = lock_pulse;
  assign bus.lost_pulse      = lost_pulse;
  assign bus.transient_count = tcount;

endmodule

// File: tb/tb_orbit_period_detector.sv
// Scoreboard bench: the driver queues hand-computed expected outputs per
// cycle, the monitor pops and compares them one cycle later.
module tb_orbit_period_detector;

  localparam int DEPTH = 16;
  localparam int PW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          locked;
    logic [PW-1:0] period;
    logic          fixed_point;
    logic          lock_pulse;
    logic          lost_pulse;
    logic [15:0]   tcount;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  want;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic stim_done = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  orbit_period_detector_if #(.DEPTH(DEPTH)) bus ();

  orbit_period_detector #(
    .DEPTH   (DEPTH),
    .CONFIRM (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input obs_t got, input obs_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got locked=%0b period=%0d fixed=%0b lock_pulse=%0b lost_pulse=%0b tcount=%0d, want locked=%0b period=%0d fixed=%0b lock_pulse=%0b lost_pulse=%0b tcount=%0d",
               name, got.locked, got.period, got.fixed_point, got.lock_pulse,
               got.lost_pulse, got.tcount, want.locked, want.period,
               want.fixed_point, want.lock_pulse, want.lost_pulse, want.tcount);
    end
  endtask

  // One clock of stimulus plus the outputs expected right after that edge.
  task automatic step(input logic r, input logic c, input logic v,
                      input logic [7:0] s, input string tag,
                      input logic l, input int p, input logic lp,
                      input logic ls, input int tc);
    exp_t e;
    @(negedge clk);
    #1;
    reset            = r;
    clear            = c;
    bus.sample_valid = v;
    bus.sample       = s;
    e.tag              = tag;
    e.want.locked      = l;
    e.want.period      = PW'(p);
    e.want.fixed_point = (p == 1);
    e.want.lock_pulse  = lp;
    e.want.lost_pulse  = ls;
    e.want.tcount      = 16'(tc);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, "reset", 1'b0, 0, 1'b0, 1'b0, 0);
  endtask

  // Monitor: compares DUT status against the queued expectation each cycle.
  initial begin
    exp_t e;
    obs_t got;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got.locked      = bus.locked;
        got.period      = bus.period;
        got.fixed_point = bus.fixed_point;
        got.lock_pulse  = bus.lock_pulse;
        got.lost_pulse  = bus.lost_pulse;
        got.tcount      = bus.transient_count;
        check(e.tag, got, e.want);
      end else if (stim_done) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat4 [4];
    pat4 = '{8'h10, 8'h20, 8'h10, 8'h30};
    bus.sample_valid = 1'b0;
    bus.sample       = 8'h00;

    // Constant stream: fixed point after five samples.
    do_reset();
    for (int k = 1; k <= 4; k++)
      step(1'b0, 1'b0, 1'b1, 8'h55, "const_search", 1'b0, 0, 1'b0, 1'b0, k);
    step(1'b0, 1'b0, 1'b1, 8'h55, "const_lock", 1'b1, 1, 1'b1, 1'b0, 5);
    step(1'b0, 1'b0, 1'b1, 8'h55, "const_hold", 1'b1, 1, 1'b0, 1'b0, 5);
    step(1'b0, 1'b0, 1'b0, 8'h99, "const_idle", 1'b1, 1, 1'b0, 1'b0, 5);

    // Sub-pattern repeat a,b,a,c converges to period 4.
    do_reset();
    for (int k = 1; k <= 20; k++)
      step(1'b0, 1'b0, 1'b1, pat4[(k - 1) % 4], "p4_search", 1'b0, 0, 1'b0, 1'b0, k);
    step(1'b0, 1'b0, 1'b1, pat4[0], "p4_lock", 1'b1, 4, 1'b1, 1'b0, 21);
    step(1'b0, 1'b0, 1'b1, pat4[1], "p4_hold", 1'b1, 4, 1'b0, 1'b0, 21);
    step(1'b0, 1'b0, 1'b0, 8'h00, "p4_idle", 1'b1, 4, 1'b0, 1'b0, 21);

    // Period 17 exceeds the history and never locks.
    do_reset();
    for (int k = 1; k <= 200; k++)
      step(1'b0, 1'b0, 1'b1, 8'((k - 1) % 17), "aperiodic", 1'b0, 0, 1'b0, 1'b0, k);
    step(1'b0, 1'b0, 1'b0, 8'h00, "aperiodic_idle", 1'b0, 0, 1'b0, 1'b0, 200);

    // Period 2 lock, then departure from the cycle.
    do_reset();
    for (int k = 1; k <= 9; k++)
      step(1'b0, 1'b0, 1'b1, (k % 2 == 1) ? 8'hAA : 8'h33, "p2_search", 1'b0, 0, 1'b0, 1'b0, k);
    step(1'b0, 1'b0, 1'b1, 8'h33, "p2_lock", 1'b1, 2, 1'b1, 1'b0, 10);
    step(1'b0, 1'b0, 1'b1, 8'hAA, "p2_hold", 1'b1, 2, 1'b0, 1'b0, 10);
    step(1'b0, 1'b0, 1'b1, 8'h00, "p2_lost", 1'b0, 0, 1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 1'b0, 8'h00, "p2_lost_idle", 1'b0, 0, 1'b0, 1'b0, 1);

    // Clear with a valid sample while locked: sample dropped, fresh relock.
    do_reset();
    for (int k = 1; k <= 4; k++)
      step(1'b0, 1'b0, 1'b1, 8'h55, "pre_clear_search", 1'b0, 0, 1'b0, 1'b0, k);
    step(1'b0, 1'b0, 1'b1, 8'h55, "pre_clear_lock", 1'b1, 1, 1'b1, 1'b0, 5);
    step(1'b0, 1'b1, 1'b1, 8'h55, "clear_with_valid", 1'b0, 0, 1'b0, 1'b0, 0);
    for (int k = 1; k <= 4; k++)
      step(1'b0, 1'b0, 1'b1, 8'h55, "post_clear_search", 1'b0, 0, 1'b0, 1'b0, k);
    step(1'b0, 1'b0, 1'b1, 8'h55, "post_clear_lock", 1'b1, 1, 1'b1, 1'b0, 5);

    // Reset mid-lock gives no lost_pulse; then alternate-cycle valid.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      if (k < 5) begin
        step(1'b0, 1'b0, 1'b1, 8'h55, "alt_search", 1'b0, 0, 1'b0, 1'b0, k);
        step(1'b0, 1'b0, 1'b0, 8'hEE, "alt_gap", 1'b0, 0, 1'b0, 1'b0, k);
      end else begin
        step(1'b0, 1'b0, 1'b1, 8'h55, "alt_lock", 1'b1, 1, 1'b1, 1'b0, 5);
        step(1'b0, 1'b0, 1'b0, 8'hEE, "alt_gap_locked", 1'b1, 1, 1'b0, 1'b0, 5);
      end
    end
    step(1'b0, 1'b0, 1'b1, 8'h55, "alt_hold", 1'b1, 1, 1'b0, 1'b0, 5);
    step(1'b0, 1'b0, 1'b0, 8'h00, "final_idle", 1'b1, 1, 1'b0, 1'b0, 5);

    stim_done = 1'b1;
  end

endmodule

// File: doc/orbit_period_detector.md
# orbit_period_detector

Consumes the 8-bit sample stream produced by the iterated nonlinear-map generator (one new state value per update) and classifies its long-run behaviour. It keeps a short history of recent samples, finds the shortest repetition period, and reports lock once that period has held for several full periods. Outputs drive status LEDs and the debug readout. A period of 1 is reported as a fixed point. Loss of lock is flagged when the orbit departs from the locked cycle.

## Interface
- DEPTH, 16: history length and maximum detectable period; legal range 2..32.
- CONFIRM, 4: number of full consecutive periods required before lock.
- PW, $clog2(DEPTH+1): width of the period output (derived; not overridden).
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous restart: flushes history and status, same effect as reset.
- sample_valid  in  1  qualifies sample; one sample is consumed per cycle when high.
- sample  in  8  current map value.
- locked  out  1  steady lock indicator.
- period  out  PW  locked period 1..DEPTH; 0 when not locked.
- fixed_point  out  1  locked && period==1.
- lock_pulse  out  1  one-cycle strobe on entry to LOCKED.
- lost_pulse  out  1  one-cycle strobe on exit from LOCKED.
- transient_count  out  16  valid samples since the last reset, clear or loss of lock, up to lock; saturates at 0xFFFF; frozen while locked.

## Operation
- History hist[0..DEPTH-1], with hist[0] the newest sample. fill counts stored entries and saturates at DEPTH.
- On each valid sample, the history shifts in the sample after the comparisons. Comparisons use the pre-shift history.
- Match vector: m[i] = (hist[i]==sample) && (i < fill).
- Smallest candidate: first = lowest i with m[i] set, plus 1. first is 0 if no entry matches.
- Registered state: cand (PW bits) and run (run counter, width clog2(DEPTH*CONFIRM+1)).
- States:
  - EMPTY: entered on reset or clear. The first valid sample goes to SEARCH with fill=1, cand=0, run=0.
  - SEARCH, per valid sample:
    - If cand≠0 and hist[cand-1]==sample: run increments.
    - Otherwise: cand←first, and run←1 if first≠0, else 0.
    - When the updated run equals cand×CONFIRM: go to LOCKED, set period←cand, pulse lock_pulse.
  - LOCKED, per valid sample:
    - If hist[period-1]==sample: stay in LOCKED.
    - Otherwise: pulse lost_pulse, set period←0, go to SEARCH. Apply the SEARCH reselect rule to this sample, restarting transient_count at 1.
- transient_count increments on every valid sample in EMPTY or SEARCH, including the sample that causes lock.
- The SEARCH rule never jumps to a shorter period while the current candidate keeps matching. Sub-pattern repeats such as a,b,a,c therefore converge to the true period.
- Periods greater than DEPTH never lock; SEARCH continues indefinitely.
- If sample_valid is low, nothing changes, including the counters and the history.

## Timing
- All outputs are registered.
- Reset and clear values: locked=0, period=0, fixed_point=0, lock_pulse=0, lost_pulse=0, transient_count=0, fill=0, state=EMPTY.
- Latency is 1 cycle. A sample accepted at edge N is reflected in the outputs after edge N.
- lock_pulse and lost_pulse are high for exactly one cycle.
- clear or reset together with sample_valid: clear/reset wins and the sample is dropped.
- Reset or clear mid-lock: all state is discarded immediately, with no lost_pulse.

## Structure
- Shared package orbit_pkg holds:
  - the state enum (EMPTY, SEARCH, LOCKED);
  - the default DEPTH and CONFIRM constants;
  - the 16-bit transient_count saturation constant.
- One combinational sub-module, orbit_match_encoder. Inputs: history, fill, sample. Outputs: the match vector and first.
- The top level holds the history shift register, the FSM and the counters.

## Test plan
- Constant 0x55 stream after reset -> lock after sample 5: lock_pulse one cycle after that sample, period=1, fixed_point=1, transient_count=5.
- Repeating 0x10,0x20,0x10,0x30 -> candidate passes through 2, then settles at 4; lock_pulse after sample 21, period=4, transient_count=21.
- Sequence 0..16 mod 17 for 200 samples (DEPTH=16) -> locked stays 0, period stays 0, transient_count=200.
- Lock on 0xAA,0x33 (period 2), then inject 0x00 -> lost_pulse for one cycle, locked=0, period=0, transient_count=1.
- While locked, assert clear together with sample_valid -> sample dropped; next cycle all outputs are 0 and the state is EMPTY. A fresh constant stream then relocks after 5 samples.
- Repeat the constant-0x55 scenario with sample_valid high only on alternate cycles -> same outputs and same counts as that scenario, with all events occurring on the valid cycles.
